// File: rtl/erm16_bus_pkg.sv
// erm16_bus_pkg
// Shared constants for the ERM16 memory/IO subsystem:
//   - I/O register addresses (full 16-bit decode)
//   - STATUS register bit positions
//   - IRQ_EN register bit positions
//   - helper that saturates a FIFO occupancy count to the 4-bit STATUS field
package erm16_bus_pkg;

  localparam logic [15:0] IO_TXDATA = 16'h0000;
  localparam logic [15:0] IO_STATUS = 16'h0001;
  localparam logic [15:0] IO_RXDATA = 16'h0002;
  localparam logic [15:0] IO_IRQ_EN = 16'h0003;
  localparam logic [15:0] IO_OVFCLR = 16'h0004;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_AVAIL = 2;
  localparam int ST_CNT_LO   = 3;  // tx_count occupies [6:3]
  localparam int ST_OVF      = 7;

  localparam int IE_RX      = 0;
  localparam int IE_TXEMPTY = 1;
  localparam int IE_OVF     = 2;

  // The STATUS count field is only 4 bits wide; deeper FIFOs read as 15.
  function automatic logic [3:0] sat_count4(input logic [31:0] count);
    return (count > 32'd15) ? 4'hF : count[3:0];
  endfunction

endpackage

// File: rtl/erm16_sync_fifo.sv
// erm16_sync_fifo
// Single-clock FIFO, first-word-fall-through head (dout is the current head).
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write request and data; accepted when not full, or when a
//                 pop happens in the same cycle
//   pop           read request; ignored when empty
//   dout          head word (valid while ~empty)
//   full, empty   occupancy flags
//   count         number of stored words (0..DEPTH)
// DEPTH must be a power of two so that the pointers wrap naturally.
module erm16_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW + 1)'(DEPTH));
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/erm16_bus_unit.sv
// erm16_bus_unit
// Memory/IO subsystem behind the ERM16 core: word RAM plus a small I/O space
// (TX FIFO, RX holding register, STATUS, IRQ_EN, OVFCLR).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   addr_bus, do_bus    address and write data from the core
//   wrmem, ioe          1 = write / 1 = I/O space
//   di_bus              read data, one cycle after the address
//   tx_data, tx_valid, tx_ready   TX FIFO head toward an external sink
//   rx_data, rx_valid, rx_ready   one-word RX holding register
//   irq                 registered level interrupt request
module erm16_bus_unit
  import erm16_bus_pkg::*;
#(
  parameter int MEM_AW   = 10,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [15:0] do_bus,
  input  logic        wrmem,
  input  logic        ioe,
  output logic [15:0] di_bus,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  // ---------------- RAM ----------------
  logic [15:0]       mem [0:(2**MEM_AW)-1];
  logic [MEM_AW-1:0] ram_idx;
  logic [15:0]       ram_rd_reg;

  assign ram_idx = addr_bus[MEM_AW-1:0];

  // Read-first: the registered read sees the contents before this edge's write.
  // Writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!ioe && wrmem && !rst) begin
      mem[ram_idx] <= do_bus;
    end
    ram_rd_reg <= mem[ram_idx];
  end

  // ---------------- I/O decode ----------------
  logic io_wr;
  logic tx_push;
  logic rx_pop;
  logic irq_en_wr;
  logic ovf_clr;

  assign io_wr     = ioe & wrmem;
  assign tx_push   = io_wr & (addr_bus == IO_TXDATA);
  assign rx_pop    = io_wr & (addr_bus == IO_RXDATA);
  assign irq_en_wr = io_wr & (addr_bus == IO_IRQ_EN);
  assign ovf_clr   = io_wr & (addr_bus == IO_OVFCLR);

  // ---------------- TX FIFO ----------------
  logic             tx_full;
  logic             tx_empty;
  logic [TX_CW-1:0] tx_count;
  logic             tx_pop;

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  erm16_sync_fifo #(
    .WIDTH(16),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_push),
    .din  (do_bus),
    .pop  (tx_pop),
    .dout (tx_data),
    .full (tx_full),
    .empty(tx_empty),
    .count(tx_count)
  );

  // ---------------- control/status registers ----------------
  logic [15:0] rx_data_reg;
  logic        rx_avail_reg;
  logic [2:0]  irq_en_reg;
  logic        ovf_reg;
  logic        irq_reg;
  logic        irq_next;

  assign rx_ready = ~rx_avail_reg;
  assign irq      = irq_reg;

  assign irq_next = (irq_en_reg[IE_RX]      & rx_avail_reg) |
                    (irq_en_reg[IE_TXEMPTY] & tx_empty)     |
                    (irq_en_reg[IE_OVF]     & ovf_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_reg  <= '0;
      rx_avail_reg <= 1'b0;
      irq_en_reg   <= '0;
      ovf_reg      <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      // Capture only while empty; a pop of an empty holder is a no-op,
      // so a capture in that cycle simply wins.
      if (rx_valid && !rx_avail_reg) begin
        rx_data_reg  <= rx_data;
        rx_avail_reg <= 1'b1;
      end else if (rx_pop) begin
        rx_avail_reg <= 1'b0;
      end
      if (irq_en_wr) irq_en_reg <= do_bus[2:0];
      // A dropped word in the same cycle as a clear keeps the flag set.
      if (tx_push && tx_full && !tx_pop) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
      irq_reg <= irq_next;
    end
  end

  // ---------------- read mux ----------------
  logic [15:0] status_word;
  logic [15:0] io_rdata;
  logic        sel_io_reg;
  logic [15:0] io_rd_reg;

  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]               = tx_full;
    status_word[ST_TX_EMPTY]              = tx_empty;
    status_word[ST_RX_AVAIL]              = rx_avail_reg;
    status_word[ST_CNT_LO +: 4]           = sat_count4(32'(tx_count));
    status_word[ST_OVF]                   = ovf_reg;
  end

  always_comb begin
    io_rdata = '0;
    case (addr_bus)
      IO_STATUS: io_rdata = status_word;
      IO_RXDATA: io_rdata = rx_avail_reg ? rx_data_reg : 16'h0000;
      IO_IRQ_EN: io_rdata = {13'b0, irq_en_reg};
      default:   io_rdata = '0;
    endcase
  end

  // The RAM output register is never reset, so reset forces the I/O path,
  // whose register clears, to present di_bus = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_io_reg <= 1'b1;
      io_rd_reg  <= '0;
    end else begin
      sel_io_reg <= ioe;
      io_rd_reg  <= io_rdata;
    end
  end

  assign di_bus = sel_io_reg ? io_rd_reg : ram_rd_reg;

endmodule
